// File: rtl/axis_sync_fifo.sv
// AXI-Stream synchronous FIFO with first-word-fall-through output, fill level,
// almost-full/almost-empty flags and an optional store-whole-packet release mode.
module axis_sync_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int AF_THRESH   = 12,
  parameter int AE_THRESH   = 4,
  parameter int PACKET_MODE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      s_tdata,
  input  logic                       s_tlast,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic [DATA_WIDTH-1:0]      m_tdata,
  output logic                       m_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW:0]         wr_ptr_reg;
  logic [AW:0]         rd_ptr_reg;
  logic [LW-1:0]       level_reg;
  logic                full;
  logic                empty;
  logic                wr_en;
  logic                rd_en;

  // Same index with differing wrap bits means DEPTH entries stored (level == DEPTH).
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  assign s_tready = !full && !reset;
  assign wr_en    = s_tvalid && s_tready;
  assign rd_en    = m_tvalid && m_tready;

  assign {m_tlast, m_tdata} = mem[rd_ptr_reg[AW-1:0]];

  assign level        = level_reg;
  assign almost_full  = (level_reg >= LW'(AF_THRESH));
  assign almost_empty = (level_reg <= LW'(AE_THRESH));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= {s_tlast, s_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      case ({wr_en, rd_en})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  generate
    if (PACKET_MODE != 0) begin : g_pkt
      logic [LW-1:0] pkt_cnt_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          pkt_cnt_reg <= '0;
        end else begin
          case ({wr_en && s_tlast, rd_en && m_tlast})
            2'b10:   pkt_cnt_reg <= pkt_cnt_reg + LW'(1);
            2'b01:   pkt_cnt_reg <= pkt_cnt_reg - LW'(1);
            default: pkt_cnt_reg <= pkt_cnt_reg;
          endcase
        end
      end

      // A full FIFO releases beats anyway so packets longer than DEPTH cannot deadlock.
      assign m_tvalid = !reset && !empty && ((pkt_cnt_reg != '0) || full);
    end else begin : g_cut
      assign m_tvalid = !reset && !empty;
    end
  endgenerate

endmodule
